y86_fde_core: RTL and testbench

- Combined fetch, decode/writeback and execute datapath of the single-cycle (SEQ) Y86-64 processor.
- Fetch, decode and execute are combinational from PC and the instruction bytes.
- The register file (15×64) and condition codes update on the rising clock edge.
- Data memory and PC update are external; this block takes valM from memory and exports valE, valA, valP, valC and cnd to them.

---
 rtl/y86_fde_core.sv | 198 +++++++++++++++++++
 tb/tb_y86_fde_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/y86_fde_core.sv
// Fetch, decode/writeback and execute datapath for a single-cycle Y86-64 core.
// Fetch, decode and ALU are combinational from PC/instr. The register file and
// condition codes update on the rising edge. Memory access and PC update live outside.
module y86_fde_core #(
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PC,
  input  logic [0:79] instr,
  input  logic [63:0] valM,
  input  logic        dmem_error,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] valE,
  output logic        cnd,
  output logic        cf,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        imem_error,
  output logic        instr_invalid,
  output logic        hlt,
  output logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi,
  output logic [63:0] r8, r9, r10, r11, r12, r13, r14
);

  localparam logic [3:0] RegRsp  = 4'h4;
  localparam logic [3:0] RegNone = 4'hF;

  logic [63:0] regs_q [15];
  logic        cf_q, zf_q, sf_q, of_q;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [64:0] add_res;
  logic        cond, ok;
  logic        cf_d, sf_d, of_d;

  assign icode = instr[0:3];
  assign ifun  = instr[4:7];
  assign ra    = instr[8:11];
  assign rb    = instr[12:15];

  assign hlt        = (icode == 4'h0);
  assign imem_error = (PC >= 64'(IMEM_SIZE));

  // Constant word, instruction length and opcode legality.
  always_comb begin
    valC          = '0;
    valP          = PC + 64'd1;
    instr_invalid = 1'b0;
    case (icode)
      4'h3, 4'h4, 4'h5: begin
        valC = {instr[72:79], instr[64:71], instr[56:63], instr[48:55],
                instr[40:47], instr[32:39], instr[24:31], instr[16:23]};
        valP = PC + 64'd10;
      end
      4'h7, 4'h8: begin
        valC = {instr[64:71], instr[56:63], instr[48:55], instr[40:47],
                instr[32:39], instr[24:31], instr[16:23], instr[8:15]};
        valP = PC + 64'd9;
      end
      4'h2, 4'h6, 4'hA, 4'hB: valP = PC + 64'd2;
      default: valP = PC + 64'd1;
    endcase
    if (icode > 4'hB)                         instr_invalid = 1'b1;
    else if (icode == 4'h6)                   instr_invalid = (ifun > 4'h3);
    else if (icode == 4'h2 || icode == 4'h7)  instr_invalid = (ifun > 4'h6);
    else                                      instr_invalid = (ifun != 4'h0);
  end

  // Register source/destination selection.
  always_comb begin
    src_a = RegNone;
    src_b = RegNone;
    dst_e = RegNone;
    dst_m = RegNone;
    case (icode)
      4'h2, 4'hA: src_a = ra;
      4'h4, 4'h6: src_a = ra;
      4'h9, 4'hB: src_a = RegRsp;
      default: ;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       src_b = rb;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RegRsp;
      default: ;
    endcase
    case (icode)
      4'h2:                   dst_e = cnd ? rb : RegNone;
      4'h3, 4'h6:             dst_e = rb;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RegRsp;
      default: ;
    endcase
    if (icode == 4'h5 || icode == 4'hB) dst_m = ra;
  end

  assign valA = (src_a == RegNone) ? 64'd0 : regs_q[src_a];
  assign valB = (src_b == RegNone) ? 64'd0 : regs_q[src_b];

  // Condition evaluation against the current CC register.
  always_comb begin
    case (ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf_q ^ of_q) | zf_q;
      4'h2:    cond = sf_q ^ of_q;
      4'h3:    cond = zf_q;
      4'h4:    cond = ~zf_q;
      4'h5:    cond = ~(sf_q ^ of_q);
      4'h6:    cond = ~(sf_q ^ of_q) & ~zf_q;
      default: cond = 1'b0;
    endcase
    cnd = (icode == 4'h2 || icode == 4'h7) ? cond : 1'b0;
  end

  assign add_res = {1'b0, valB} + {1'b0, valA};

  // ALU result and the flags an OPq would produce.
  always_comb begin
    valE = '0;
    cf_d = 1'b0;
    of_d = 1'b0;
    case (icode)
      4'h2:       valE = valA;
      4'h3:       valE = valC;
      4'h4, 4'h5: valE = valB + valC;
      4'h6: begin
        case (ifun[1:0])
          2'd0: begin
            valE = add_res[63:0];
            cf_d = add_res[64];
            of_d = (valA[63] == valB[63]) && (valE[63] != valA[63]);
          end
          2'd1: begin
            valE = valB - valA;
            cf_d = (valB < valA);
            of_d = (valA[63] != valB[63]) && (valE[63] != valB[63]);
          end
          2'd2:    valE = valB & valA;
          default: valE = valB ^ valA;
        endcase
      end
      4'h8, 4'hA: valE = valB - 64'd8;
      4'h9, 4'hB: valE = valB + 64'd8;
      default: ;
    endcase
    sf_d = valE[63];
  end

  assign ok = ~(instr_invalid | imem_error | hlt | dmem_error);

  // Register file and CC writeback; the valM write is last so it wins on dstE == dstM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      zf_q <= 1'b1;
      cf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (ok) begin
      if (dst_e != RegNone) regs_q[dst_e] <= valE;
      if (dst_m != RegNone) regs_q[dst_m] <= valM;
      if (icode == 4'h6) begin
        zf_q <= (valE == 64'd0);
        sf_q <= sf_d;
        of_q <= of_d;
        cf_q <= cf_d;
      end
    end
  end

  assign cf = cf_q;
  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;

  assign rax = regs_q[0];
  assign rcx = regs_q[1];
  assign rdx = regs_q[2];
  assign rbx = regs_q[3];
  assign rsp = regs_q[4];
  assign rbp = regs_q[5];
  assign rsi = regs_q[6];
  assign rdi = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];

endmodule

// File: tb/tb_y86_fde_core.sv
// Directed bench for y86_fde_core: hand-computed vectors, checked around each clock edge.
module tb_y86_fde_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] PC;
  logic [0:79] instr;
  logic [63:0] valM;
  logic        dmem_error;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valC, valP, valA, valB, valE;
  logic        cnd, cf, zf, sf, of, imem_error, instr_invalid, hlt;
  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;

  int n_checks = 0;
  int n_pass   = 0;

  y86_fde_core #(.IMEM_SIZE(1024)) dut (
    .clk(clk), .rst(rst), .PC(PC), .instr(instr), .valM(valM), .dmem_error(dmem_error),
    .icode(icode), .ifun(ifun), .ra(ra), .rb(rb), .valC(valC), .valP(valP),
    .valA(valA), .valB(valB), .valE(valE), .cnd(cnd),
    .cf(cf), .zf(zf), .sf(sf), .of(of),
    .imem_error(imem_error), .instr_invalid(instr_invalid), .hlt(hlt),
    .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp), .rsi(rsi),
    .rdi(rdi), .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [0:79] irmov(input logic [3:0] r, input logic [63:0] v);
    logic [0:79] x;
    x = '0;
    x[0:7]  = 8'h30;
    x[8:15] = {4'hF, r};
    for (int k = 0; k < 8; k++) x[16 + 8 * k +: 8] = v[8 * k +: 8];
    return x;
  endfunction

  function automatic logic [0:79] two(input logic [7:0] b0, input logic [7:0] b1);
    return {b0, b1, 64'h0};
  endfunction

  // Drive a new instruction away from the active edge, let combinational logic settle.
  task automatic apply(input logic [0:79] i, input logic [63:0] pc, input logic [63:0] m);
    @(negedge clk);
    instr = i;
    PC    = pc;
    valM  = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [3:0] r, input logic [63:0] v);
    apply(irmov(r, v), 64'd0, 64'd0);
    tick();
  endtask

  logic [0:79] jinstr;

  initial begin
    rst = 1'b1;
    dmem_error = 1'b0;
    apply(two(8'h10, 8'h00), 64'd0, 64'd0);
    tick();
    check("rst_rax", rax, 64'd0);
    check("rst_rsp", rsp, 64'd0);
    check("rst_zf", {63'd0, zf}, 64'd1);
    check("rst_cf", {63'd0, cf}, 64'd0);
    rst = 1'b0;

    // irmovq $0x10,%rax
    apply(irmov(4'h0, 64'h10), 64'd0, 64'd0);
    check("irmov_icode", {60'd0, icode}, 64'd3);
    check("irmov_valC", valC, 64'h10);
    check("irmov_valP", valP, 64'd10);
    check("irmov_valE", valE, 64'h10);
    check("irmov_inv", {63'd0, instr_invalid}, 64'd0);
    tick();
    check("irmov_rax", rax, 64'h10);
    check("irmov_zf", {63'd0, zf}, 64'd1);

    // je 0x1234 at PC 0x40, zf=1 after reset
    jinstr = '0;
    jinstr[0:7]   = 8'h73;
    jinstr[8:15]  = 8'h34;
    jinstr[16:23] = 8'h12;
    apply(jinstr, 64'h40, 64'd0);
    check("je_valC", valC, 64'h1234);
    check("je_valP", valP, 64'h49);
    check("je_cnd", {63'd0, cnd}, 64'd1);

    // subq %rax,%rbx with rax=5, rbx=3
    set_reg(4'h0, 64'd5);
    set_reg(4'h3, 64'd3);
    apply(two(8'h61, 8'h03), 64'd0, 64'd0);
    check("sub_valA", valA, 64'd5);
    check("sub_valB", valB, 64'd3);
    check("sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("sub_rbx", rbx, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_sf", {63'd0, sf}, 64'd1);
    check("sub_zf", {63'd0, zf}, 64'd0);
    check("sub_cf", {63'd0, cf}, 64'd1);
    check("sub_of", {63'd0, of}, 64'd0);
    apply(two(8'h72, 8'h00), 64'd0, 64'd0);
    check("jl_cnd", {63'd0, cnd}, 64'd1);
    apply(two(8'h76, 8'h00), 64'd0, 64'd0);
    check("jg_cnd", {63'd0, cnd}, 64'd0);

    // addq %rax,%rbx overflowing into the sign bit
    set_reg(4'h0, 64'h7FFF_FFFF_FFFF_FFFF);
    set_reg(4'h3, 64'd1);
    apply(two(8'h60, 8'h03), 64'd0, 64'd0);
    check("add_valE", valE, 64'h8000_0000_0000_0000);
    tick();
    check("add_rbx", rbx, 64'h8000_0000_0000_0000);
    check("add_of", {63'd0, of}, 64'd1);
    check("add_sf", {63'd0, sf}, 64'd1);
    check("add_cf", {63'd0, cf}, 64'd0);
    check("add_zf", {63'd0, zf}, 64'd0);

    // cmovl %rax,%rcx: sf^of=0, no write; cmovge %rax,%rcx: writes
    apply(two(8'h22, 8'h01), 64'd0, 64'd0);
    check("cmovl_cnd", {63'd0, cnd}, 64'd0);
    tick();
    check("cmovl_rcx", rcx, 64'd0);
    apply(two(8'h25, 8'h01), 64'd0, 64'd0);
    check("cmovge_cnd", {63'd0, cnd}, 64'd1);
    tick();
    check("cmovge_rcx", rcx, 64'h7FFF_FFFF_FFFF_FFFF);

    // pushq %rax then popq %rsp
    set_reg(4'h4, 64'h100);
    apply(two(8'hA0, 8'h0F), 64'd0, 64'd0);
    check("push_valA", valA, 64'h7FFF_FFFF_FFFF_FFFF);
    check("push_valE", valE, 64'hF8);
    tick();
    check("push_rsp", rsp, 64'hF8);
    apply(two(8'hB0, 8'h4F), 64'd0, 64'h55);
    check("pop_valE", valE, 64'h100);
    tick();
    check("pop_rsp", rsp, 64'h55);

    // Illegal opcodes
    apply(two(8'hC0, 8'h00), 64'd0, 64'd0);
    check("c0_inv", {63'd0, instr_invalid}, 64'd1);
    tick();
    check("c0_rsp", rsp, 64'h55);
    apply(two(8'h64, 8'h03), 64'd0, 64'd0);
    check("op4_inv", {63'd0, instr_invalid}, 64'd1);
    tick();
    check("op4_rbx", rbx, 64'h8000_0000_0000_0000);
    check("op4_of", {63'd0, of}, 64'd1);
    check("op4_zf", {63'd0, zf}, 64'd0);

    // halt
    apply(two(8'h00, 8'h00), 64'h20, 64'd0);
    check("halt_hlt", {63'd0, hlt}, 64'd1);
    check("halt_valP", valP, 64'h21);

    // Instruction memory bound
    apply(irmov(4'h0, 64'h99), 64'd1024, 64'd0);
    check("imem_err", {63'd0, imem_error}, 64'd1);
    tick();
    check("imem_rax", rax, 64'h7FFF_FFFF_FFFF_FFFF);
    apply(irmov(4'h0, 64'h99), 64'd1023, 64'd0);
    check("imem_edge", {63'd0, imem_error}, 64'd0);
    tick();
    check("imem_edge_rax", rax, 64'h99);

    // Data memory error suppresses writeback
    dmem_error = 1'b1;
    apply(irmov(4'h0, 64'hAA), 64'd0, 64'd0);
    tick();
    check("dmem_rax", rax, 64'h99);
    dmem_error = 1'b0;

    // xorq %rax,%rax then addq %rax,%rbx
    apply(two(8'h63, 8'h00), 64'd0, 64'd0);
    tick();
    check("xor_rax", rax, 64'd0);
    check("xor_zf", {63'd0, zf}, 64'd1);
    check("xor_of", {63'd0, of}, 64'd0);
    apply(two(8'h60, 8'h03), 64'd0, 64'd0);
    tick();
    check("add0_zf", {63'd0, zf}, 64'd0);
    check("add0_sf", {63'd0, sf}, 64'd1);

    // Reset mid-sequence beats a pending write
    rst = 1'b1;
    apply(irmov(4'h4, 64'h77), 64'd0, 64'd0);
    tick();
    check("rst2_rsp", rsp, 64'd0);
    check("rst2_rbx", rbx, 64'd0);
    check("rst2_rcx", rcx, 64'd0);
    check("rst2_zf", {63'd0, zf}, 64'd1);
    check("rst2_sf", {63'd0, sf}, 64'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
